// File: rtl/xy_dac_scan_mux_if.sv
// xy_dac_scan_mux_if: view-generator point streams in, scope DAC/Z out.
// slave: scan mux side (en + x/y pairs in; dac_*, blank, src, tick out).
interface xy_dac_scan_mux_if;
    logic [2:0] en;
    logic [7:0] x_l;
    logic [7:0] y_l;
    logic [7:0] x_r;
    logic [7:0] y_r;
    logic [7:0] x_b;
    logic [7:0] y_b;
    logic [7:0] dac_x;
    logic [7:0] dac_y;
    logic       dac_wr;
    logic       blank;
    logic [1:0] src;
    logic       frame_tick;

    modport slave (
        input  en, x_l, y_l, x_r, y_r, x_b, y_b,
        output dac_x, dac_y, dac_wr, blank, src, frame_tick
    );

    modport master (
        output en, x_l, y_l, x_r, y_r, x_b, y_b,
        input  dac_x, dac_y, dac_wr, blank, src, frame_tick
    );
endinterface

// File: rtl/xy_dac_scan_mux.sv
// xy_dac_scan_mux: time-multiplexes L/R/ball point streams onto one X/Y DAC.
// Ports: clk, rst_n (async, active low), bus (slave) carrying en mask,
// source coords in and dac_x/dac_y/dac_wr/blank/src/frame_tick out.
module xy_dac_scan_mux #(
    parameter int DWELL_PLATE = 64,
    parameter int DWELL_BALL  = 16,
    parameter int SETTLE      = 4,
    parameter int CENTER      = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    xy_dac_scan_mux_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_VISIBLE
    } state_t;

    localparam logic [7:0] CTR        = 8'(CENTER);
    localparam logic [3:0] SET_LAST   = 4'(SETTLE - 1);
    localparam logic [7:0] PLATE_LAST = 8'(DWELL_PLATE - 1);
    localparam logic [7:0] BALL_LAST  = 8'(DWELL_BALL - 1);

    state_t     state;
    logic [2:0] en_q;
    logic [3:0] settle_cnt;
    logic [7:0] dwell_cnt;

    logic [1:0]  hi_src;
    logic [1:0]  nxt_src;
    logic        wrap;
    logic [7:0]  dwell_last;
    logic [15:0] cur_xy;
    logic [15:0] nxt_xy;

    // 3 means "no source".
    function automatic logic [1:0] lowest(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [2:0] above(input logic [1:0] s);
        unique case (s)
            2'd0:    return 3'b110;
            2'd1:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] pick(
        input logic [1:0]  s,
        input logic [15:0] l,
        input logic [15:0] r,
        input logic [15:0] b
    );
        unique case (s)
            2'd0:    return l;
            2'd1:    return r;
            2'd2:    return b;
            default: return {CTR, CTR};
        endcase
    endfunction

    // In IDLE src is 3, so hi_src is none and nxt_src falls back to the
    // lowest bit of the live mask -- the same path as a frame wrap.
    always_comb begin
        hi_src  = lowest(en_q & above(bus.src));
        wrap    = (hi_src == 2'd3);
        nxt_src = wrap ? lowest(bus.en) : hi_src;
        dwell_last = (bus.src == 2'd2) ? BALL_LAST : PLATE_LAST;
        cur_xy = pick(bus.src, {bus.x_l, bus.y_l},
                      {bus.x_r, bus.y_r}, {bus.x_b, bus.y_b});
        nxt_xy = pick(nxt_src, {bus.x_l, bus.y_l},
                      {bus.x_r, bus.y_r}, {bus.x_b, bus.y_b});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            en_q           <= 3'b000;
            settle_cnt     <= 4'd0;
            dwell_cnt      <= 8'd0;
            bus.dac_x      <= CTR;
            bus.dac_y      <= CTR;
            bus.dac_wr     <= 1'b0;
            bus.blank      <= 1'b1;
            bus.src        <= 2'd3;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.dac_wr     <= 1'b0;
            bus.frame_tick <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    en_q <= bus.en;
                    if (bus.en != 3'b000) begin
                        state      <= S_SETTLE;
                        settle_cnt <= 4'd0;
                        bus.src    <= nxt_src;
                        {bus.dac_x, bus.dac_y} <= nxt_xy;
                        bus.dac_wr <= 1'b1;
                        bus.blank  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        state      <= S_VISIBLE;
                        dwell_cnt  <= 8'd0;
                        {bus.dac_x, bus.dac_y} <= cur_xy;
                        bus.dac_wr <= 1'b1;
                        bus.blank  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_VISIBLE: begin
                    if (dwell_cnt != dwell_last) begin
                        dwell_cnt  <= dwell_cnt + 8'd1;
                        {bus.dac_x, bus.dac_y} <= cur_xy;
                        bus.dac_wr <= 1'b1;
                    end else begin
                        if (wrap) begin
                            bus.frame_tick <= 1'b1;
                            en_q           <= bus.en;
                        end
                        dwell_cnt  <= 8'd0;
                        settle_cnt <= 4'd0;
                        bus.dac_wr <= 1'b1;
                        if (nxt_src == 2'd3) begin
                            // Park the beam at center on the way out.
                            state     <= S_IDLE;
                            bus.dac_x <= CTR;
                            bus.dac_y <= CTR;
                            bus.blank <= 1'b1;
                            bus.src   <= 2'd3;
                        end else if (nxt_src == bus.src) begin
                            {bus.dac_x, bus.dac_y} <= cur_xy;
                        end else begin
                            state     <= S_SETTLE;
                            bus.src   <= nxt_src;
                            {bus.dac_x, bus.dac_y} <= nxt_xy;
                            bus.blank <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xy_dac_scan_mux.sv
// tb_xy_dac_scan_mux: directed bench for xy_dac_scan_mux at default params.
// Observed vector = {dac_x, dac_y, dac_wr, blank, src, frame_tick}.
module tb_xy_dac_scan_mux;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    xy_dac_scan_mux_if bus ();

    xy_dac_scan_mux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [20:0] outs();
        return {bus.dac_x, bus.dac_y, bus.dac_wr,
                bus.blank, bus.src, bus.frame_tick};
    endfunction

    task automatic chk(input string tag, input logic [20:0] obs,
                       input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] x,
                       input logic [7:0] y, input logic wr,
                       input logic bl, input logic [1:0] s,
                       input logic tk);
        @(posedge clk);
        #1;
        chk(tag, outs(), {x, y, wr, bl, s, tk});
    endtask

    task automatic run(input int n, input string tag,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic wr, input logic bl,
                       input logic [1:0] s, input logic tk);
        repeat (n) cyc(tag, x, y, wr, bl, s, tk);
    endtask

    task automatic set_xy(input logic [7:0] xl, input logic [7:0] yl,
                          input logic [7:0] xr, input logic [7:0] yr,
                          input logic [7:0] xb, input logic [7:0] yb);
        bus.x_l = xl; bus.y_l = yl;
        bus.x_r = xr; bus.y_r = yr;
        bus.x_b = xb; bus.y_b = yb;
    endtask

    localparam logic [20:0] RST_V = {8'd128, 8'd128, 1'b0, 1'b1,
                                     2'd3, 1'b0};

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        bus.en   = 3'($urandom);
        set_xy(8'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom));

        // 1. reset hold with random inputs
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rst_hold0", outs(), RST_V);
        bus.en = 3'b111;
        set_xy(8'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom));
        repeat (2) @(posedge clk);
        #1 chk("rst_hold1", outs(), RST_V);

        // 2. all sources, two full frames
        set_xy(8'd0, 8'd40, 8'd255, 8'd90, 8'd100, 8'd7);
        bus.en = 3'b111;
        @(negedge clk) rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            cyc("f_setL0", 8'd0, 8'd40, 1, 1, 2'd0, f == 1);
            run(3, "f_setL", 8'd0, 8'd40, 0, 1, 2'd0, 0);
            run(64, "f_visL", 8'd0, 8'd40, 1, 0, 2'd0, 0);
            cyc("f_setR0", 8'd255, 8'd90, 1, 1, 2'd1, 0);
            run(3, "f_setR", 8'd255, 8'd90, 0, 1, 2'd1, 0);
            run(64, "f_visR", 8'd255, 8'd90, 1, 0, 2'd1, 0);
            cyc("f_setB0", 8'd100, 8'd7, 1, 1, 2'd2, 0);
            run(3, "f_setB", 8'd100, 8'd7, 0, 1, 2'd2, 0);
            run(16, "f_visB", 8'd100, 8'd7, 1, 0, 2'd2, 0);
        end
        cyc("f3_setL0", 8'd0, 8'd40, 1, 1, 2'd0, 1);
        run(3, "f3_setL", 8'd0, 8'd40, 0, 1, 2'd0, 0);
        run(10, "f3_visL", 8'd0, 8'd40, 1, 0, 2'd0, 0);

        // 1b. async reset mid-visible, no clock edge
        rst_n = 1'b0;
        #1 chk("rst_async", outs(), RST_V);

        // 3. ball only
        bus.en = 3'b100;
        @(negedge clk) rst_n = 1'b1;
        cyc("b_set0", 8'd100, 8'd7, 1, 1, 2'd2, 0);
        run(3, "b_set", 8'd100, 8'd7, 0, 1, 2'd2, 0);
        run(16, "b_vis", 8'd100, 8'd7, 1, 0, 2'd2, 0);
        for (int k = 0; k < 2; k++) begin
            cyc("b_tick", 8'd100, 8'd7, 1, 0, 2'd2, 1);
            run(15, "b_vis", 8'd100, 8'd7, 1, 0, 2'd2, 0);
        end

        // 4. mask change at cycle 50 of a frame
        rst_n = 1'b0;
        #1 chk("rst_async2", outs(), RST_V);
        bus.en = 3'b111;
        @(negedge clk) rst_n = 1'b1;
        cyc("m_setL0", 8'd0, 8'd40, 1, 1, 2'd0, 0);
        run(3, "m_setL", 8'd0, 8'd40, 0, 1, 2'd0, 0);
        run(46, "m_visL", 8'd0, 8'd40, 1, 0, 2'd0, 0);
        bus.en = 3'b001;
        run(18, "m_visL", 8'd0, 8'd40, 1, 0, 2'd0, 0);
        cyc("m_setR0", 8'd255, 8'd90, 1, 1, 2'd1, 0);
        run(3, "m_setR", 8'd255, 8'd90, 0, 1, 2'd1, 0);
        run(64, "m_visR", 8'd255, 8'd90, 1, 0, 2'd1, 0);
        cyc("m_setB0", 8'd100, 8'd7, 1, 1, 2'd2, 0);
        run(3, "m_setB", 8'd100, 8'd7, 0, 1, 2'd2, 0);
        run(16, "m_visB", 8'd100, 8'd7, 1, 0, 2'd2, 0);
        cyc("l_setL0", 8'd0, 8'd40, 1, 1, 2'd0, 1);
        run(3, "l_setL", 8'd0, 8'd40, 0, 1, 2'd0, 0);
        run(64, "l_visL", 8'd0, 8'd40, 1, 0, 2'd0, 0);
        cyc("l_tick", 8'd0, 8'd40, 1, 0, 2'd0, 1);
        run(63, "l_visL", 8'd0, 8'd40, 1, 0, 2'd0, 0);
        cyc("l_tick", 8'd0, 8'd40, 1, 0, 2'd0, 1);
        run(10, "l_visL", 8'd0, 8'd40, 1, 0, 2'd0, 0);

        // 5. disable mid-frame, park, re-enable R
        bus.en = 3'b000;
        run(53, "z_visL", 8'd0, 8'd40, 1, 0, 2'd0, 0);
        cyc("z_park", 8'd128, 8'd128, 1, 1, 2'd3, 1);
        run(5, "z_idle", 8'd128, 8'd128, 0, 1, 2'd3, 0);
        bus.en = 3'b010;
        cyc("r_setR0", 8'd255, 8'd90, 1, 1, 2'd1, 0);
        run(3, "r_setR", 8'd255, 8'd90, 0, 1, 2'd1, 0);
        run(64, "r_visR", 8'd255, 8'd90, 1, 0, 2'd1, 0);
        cyc("r_tick", 8'd255, 8'd90, 1, 0, 2'd1, 1);

        // 6. y_l ramp tracking, one cycle latency
        rst_n = 1'b0;
        #1 chk("rst_async3", outs(), RST_V);
        bus.en = 3'b001;
        bus.x_l = 8'h33;
        bus.y_l = 8'd0;
        @(negedge clk) rst_n = 1'b1;
        cyc("t_set0", 8'h33, 8'd0, 1, 1, 2'd0, 0);
        run(3, "t_set", 8'h33, 8'd0, 0, 1, 2'd0, 0);
        for (int i = 0; i < 64; i++) begin
            cyc("t_ramp", 8'h33, 8'(i), 1, 0, 2'd0, 0);
            bus.y_l = 8'(i + 1);
        end
        cyc("t_wrap", 8'h33, 8'd64, 1, 0, 2'd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
